// File: rtl/sat_pkg.sv
// Shared encodings and packed record layouts for the SAT engine's bin-image storage.
package sat_pkg;

  localparam int unsigned NUM_CLAUSES_DEF      = 8;
  localparam int unsigned NUM_VARS_DEF         = 8;
  localparam int unsigned NUM_LVLS_DEF         = 8;
  localparam int unsigned WIDTH_LVL_DEF        = 16;
  localparam int unsigned WIDTH_BIN_ID_DEF     = 10;
  localparam int unsigned WIDTH_VAR_STATES_DEF = 3 + WIDTH_LVL_DEF;
  localparam int unsigned WIDTH_LVL_STATES_DEF = WIDTH_BIN_ID_DEF + 1;

  localparam logic [1:0] LIT_NONE = 2'd0;
  localparam logic [1:0] LIT_NEG  = 2'd1;
  localparam logic [1:0] LIT_POS  = 2'd2;

  localparam logic [1:0] VAL_FREE  = 2'd0;
  localparam logic [1:0] VAL_FALSE = 2'd1;
  localparam logic [1:0] VAL_TRUE  = 2'd2;

  typedef struct packed {
    logic [1:0]               value;
    logic                     implied;
    logic [WIDTH_LVL_DEF-1:0] level;
  } var_state_t;

  typedef struct packed {
    logic [WIDTH_BIN_ID_DEF-1:0] dcd_bin;
    logic                        has_bkt;
  } lvl_state_t;

endpackage

// File: rtl/masked_reg_bank.sv
// Bank of equal-width registers, each loaded when its mask bit is set.
module masked_reg_bank #(
  parameter int unsigned Entries = 8,
  parameter int unsigned Width   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic [Entries-1:0]       we_i,
  input  logic [Entries*Width-1:0] d_i,
  output logic [Entries*Width-1:0] q_o
);

  logic [Entries*Width-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (clear_i) begin
      mem_q <= '0;
    end else begin
      for (int unsigned i = 0; i < Entries; i++) begin
        if (we_i[i]) begin
          mem_q[i*Width +: Width] <= d_i[i*Width +: Width];
        end
      end
    end
  end

  assign q_o = mem_q;

endmodule

// File: rtl/clause_array.sv
// Clause rows, per-variable state and per-level state for one bin image, written as
// separated fields and exposed in the packed layouts the SAT engine consumes.
module clause_array
  import sat_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES      = NUM_CLAUSES_DEF,
  parameter int unsigned NUM_VARS         = NUM_VARS_DEF,
  parameter int unsigned NUM_LVLS         = NUM_LVLS_DEF,
  parameter int unsigned WIDTH_LVL        = WIDTH_LVL_DEF,
  parameter int unsigned WIDTH_BIN_ID     = WIDTH_BIN_ID_DEF,
  parameter int unsigned WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
  parameter int unsigned WIDTH_LVL_STATES = WIDTH_LVL_STATES_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_i,
  input  logic [NUM_CLAUSES-1:0]               wr_row_i,
  input  logic [NUM_VARS*2-1:0]                clause_i,
  input  logic [$clog2(NUM_CLAUSES)-1:0]       rd_row_i,
  output logic [NUM_VARS*2-1:0]                clause_o,
  output logic [NUM_CLAUSES*NUM_VARS*2-1:0]    carray_o,
  input  logic [NUM_VARS-1:0]                  wr_var_i,
  input  logic [2*NUM_VARS-1:0]                vs_value_i,
  input  logic [NUM_VARS-1:0]                  vs_implied_i,
  input  logic [WIDTH_LVL*NUM_VARS-1:0]        vs_level_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [NUM_LVLS-1:0]                  wr_lvl_i,
  input  logic [WIDTH_BIN_ID*NUM_LVLS-1:0]     ls_dcd_bin_i,
  input  logic [NUM_LVLS-1:0]                  ls_has_bkt_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o
);

  localparam int unsigned RowW = 2 * NUM_VARS;

  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_wdata;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_wdata;
  logic [NUM_CLAUSES*RowW-1:0]          row_wdata;

  // Every selected row receives the same clause data.
  assign row_wdata = {NUM_CLAUSES{clause_i}};

  always_comb begin
    vs_wdata = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      vs_wdata[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] =
          {vs_value_i[2*i +: 2], vs_implied_i[i], vs_level_i[i*WIDTH_LVL +: WIDTH_LVL]};
    end
  end

  always_comb begin
    ls_wdata = '0;
    for (int unsigned j = 0; j < NUM_LVLS; j++) begin
      ls_wdata[j*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] =
          {ls_dcd_bin_i[j*WIDTH_BIN_ID +: WIDTH_BIN_ID], ls_has_bkt_i[j]};
    end
  end

  masked_reg_bank #(
    .Entries(NUM_CLAUSES),
    .Width  (RowW)
  ) u_rows (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear_i),
    .we_i   (wr_row_i),
    .d_i    (row_wdata),
    .q_o    (carray_o)
  );

  masked_reg_bank #(
    .Entries(NUM_VARS),
    .Width  (WIDTH_VAR_STATES)
  ) u_vars (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear_i),
    .we_i   (wr_var_i),
    .d_i    (vs_wdata),
    .q_o    (vars_states_o)
  );

  masked_reg_bank #(
    .Entries(NUM_LVLS),
    .Width  (WIDTH_LVL_STATES)
  ) u_lvls (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear_i),
    .we_i   (wr_lvl_i),
    .d_i    (ls_wdata),
    .q_o    (lvl_states_o)
  );

  // Indices with no matching row fall through to zero.
  always_comb begin
    clause_o = '0;
    for (int unsigned r = 0; r < NUM_CLAUSES; r++) begin
      if (32'(rd_row_i) == r) begin
        clause_o = carray_o[r*RowW +: RowW];
      end
    end
  end

endmodule

// File: tb/tb_clause_array.sv
// Table-driven bench for clause_array with a reference-model scoreboard.
module tb_clause_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear_i;
  logic [7:0]   wr_row_i;
  logic [15:0]  clause_i;
  logic [2:0]   rd_row_i;
  logic [15:0]  clause_o;
  logic [127:0] carray_o;
  logic [7:0]   wr_var_i;
  logic [15:0]  vs_value_i;
  logic [7:0]   vs_implied_i;
  logic [127:0] vs_level_i;
  logic [151:0] vars_states_o;
  logic [7:0]   wr_lvl_i;
  logic [79:0]  ls_dcd_bin_i;
  logic [7:0]   ls_has_bkt_i;
  logic [87:0]  lvl_states_o;

  clause_array dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .wr_row_i     (wr_row_i),
    .clause_i     (clause_i),
    .rd_row_i     (rd_row_i),
    .clause_o     (clause_o),
    .carray_o     (carray_o),
    .wr_var_i     (wr_var_i),
    .vs_value_i   (vs_value_i),
    .vs_implied_i (vs_implied_i),
    .vs_level_i   (vs_level_i),
    .vars_states_o(vars_states_o),
    .wr_lvl_i     (wr_lvl_i),
    .ls_dcd_bin_i (ls_dcd_bin_i),
    .ls_has_bkt_i (ls_has_bkt_i),
    .lvl_states_o (lvl_states_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    bit           clear;
    logic [7:0]   wr_row;
    logic [15:0]  clause;
    logic [2:0]   rd_row;
    logic [7:0]   wr_var;
    logic [15:0]  vs_value;
    logic [7:0]   vs_implied;
    logic [127:0] vs_level;
    logic [7:0]   wr_lvl;
    logic [79:0]  ls_dcd;
    logic [7:0]   ls_bkt;
    logic [15:0]  exp_clause;
    bit           pre_chk;
    logic [15:0]  pre_clause;
  } vec_t;

  typedef struct {
    logic [127:0] carray;
    logic [151:0] vars;
    logic [87:0]  lvl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  logic [15:0] m_row[8];
  logic [18:0] m_vs[8];
  logic [10:0] m_ls[8];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t idle(input logic [2:0] rd, input logic [15:0] exp);
    vec_t v;
    v.rst = 1'b1;        v.clear = 1'b0;
    v.wr_row = '0;       v.clause = '0;      v.rd_row = rd;
    v.wr_var = '0;       v.vs_value = '0;    v.vs_implied = '0;  v.vs_level = '0;
    v.wr_lvl = '0;       v.ls_dcd = '0;      v.ls_bkt = '0;
    v.exp_clause = exp;  v.pre_chk = 1'b0;   v.pre_clause = '0;
    return v;
  endfunction

  task automatic model_update(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      if (!v.rst || v.clear) begin
        m_row[i] = '0;
        m_vs[i]  = '0;
        m_ls[i]  = '0;
      end else begin
        if (v.wr_row[i]) m_row[i] = v.clause;
        if (v.wr_var[i]) m_vs[i] = {v.vs_value[2*i +: 2], v.vs_implied[i], v.vs_level[16*i +: 16]};
        if (v.wr_lvl[i]) m_ls[i] = {v.ls_dcd[10*i +: 10], v.ls_bkt[i]};
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.rst;           clear_i = v.clear;
    wr_row_i = v.wr_row;   clause_i = v.clause;     rd_row_i = v.rd_row;
    wr_var_i = v.wr_var;   vs_value_i = v.vs_value; vs_implied_i = v.vs_implied;
    vs_level_i = v.vs_level;
    wr_lvl_i = v.wr_lvl;   ls_dcd_bin_i = v.ls_dcd; ls_has_bkt_i = v.ls_bkt;
    model_update(v);
    for (int i = 0; i < 8; i++) begin
      e.carray[16*i +: 16] = m_row[i];
      e.vars[19*i +: 19]   = m_vs[i];
      e.lvl[11*i +: 11]    = m_ls[i];
    end
    sb.push_back(e);
    if (v.pre_chk) begin
      #1;
      check($sformatf("v%0d no_bypass clause_o", idx), 256'(clause_o), 256'(v.pre_clause));
    end
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check($sformatf("v%0d carray_o", idx), 256'(carray_o), 256'(got.carray));
    check($sformatf("v%0d vars_states_o", idx), 256'(vars_states_o), 256'(got.vars));
    check($sformatf("v%0d lvl_states_o", idx), 256'(lvl_states_o), 256'(got.lvl));
    check($sformatf("v%0d clause_o", idx), 256'(clause_o), 256'(v.exp_clause));
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;  clear_i = 1'b0;  wr_row_i = '0;  clause_i = '0;  rd_row_i = '0;
    wr_var_i = '0;  vs_value_i = '0;  vs_implied_i = '0;  vs_level_i = '0;
    wr_lvl_i = '0;  ls_dcd_bin_i = '0;  ls_has_bkt_i = '0;
    for (int i = 0; i < 8; i++) begin
      m_row[i] = 'x;  m_vs[i] = 'x;  m_ls[i] = 'x;
    end

    // 0-1: reset then release with no writes
    v = idle(3'd0, 16'h0000); v.rst = 1'b0; vecs.push_back(v);
    v = idle(3'd0, 16'h0000); vecs.push_back(v);
    // 2-4: rows {2,0,1,..}, {0,2,0,1,..}, {0,0,2,0,2,..}
    v = idle(3'd0, 16'h0012); v.wr_row = 8'h01; v.clause = 16'h0012;
    v.pre_chk = 1'b1; v.pre_clause = 16'h0000; vecs.push_back(v);
    v = idle(3'd0, 16'h0012); v.wr_row = 8'h02; v.clause = 16'h0048; vecs.push_back(v);
    v = idle(3'd1, 16'h0048); v.wr_row = 8'h04; v.clause = 16'h0220; vecs.push_back(v);
    // 5-7: read sweep, unwritten rows read zero
    vecs.push_back(idle(3'd2, 16'h0220));
    vecs.push_back(idle(3'd3, 16'h0000));
    vecs.push_back(idle(3'd7, 16'h0000));
    // 8: all vars written, var0 = {true, implied, level 5}
    v = idle(3'd0, 16'h0012); v.wr_var = 8'hFF; v.vs_value = 16'h0002;
    v.vs_implied = 8'h01; v.vs_level = 128'h5; vecs.push_back(v);
    // 9: only var1 written; var0 inputs differ but are masked off
    v = idle(3'd0, 16'h0012); v.wr_var = 8'h02; v.vs_value = 16'h0007;
    v.vs_implied = 8'h01; v.vs_level = 128'h0009_1234; vecs.push_back(v);
    // 10: all levels written, level0 = {bin 3, bkt}
    v = idle(3'd0, 16'h0012); v.wr_lvl = 8'hFF; v.ls_dcd = 80'h3; v.ls_bkt = 8'h01;
    vecs.push_back(v);
    // 11: only level7 written = {bin 1023, no bkt}; level0 inputs masked off
    v = idle(3'd0, 16'h0012); v.wr_lvl = 8'h80; v.ls_dcd = '0;
    v.ls_dcd[79:70] = 10'h3FF; v.ls_dcd[9:0] = 10'h155; v.ls_bkt = 8'h01; vecs.push_back(v);
    // 12-13: multi-row write of rows 0 and 7
    v = idle(3'd0, 16'hAAAA); v.wr_row = 8'h81; v.clause = 16'hAAAA;
    v.pre_chk = 1'b1; v.pre_clause = 16'h0012; vecs.push_back(v);
    vecs.push_back(idle(3'd7, 16'hAAAA));
    // 14: clear overrides every write mask
    v = idle(3'd7, 16'h0000); v.clear = 1'b1; v.wr_row = 8'hFF; v.clause = 16'hFFFF;
    v.wr_var = 8'hFF; v.vs_value = 16'hFFFF; v.vs_implied = 8'hFF; v.vs_level = '1;
    v.wr_lvl = 8'hFF; v.ls_dcd = '1; v.ls_bkt = 8'hFF; vecs.push_back(v);
    // 15: all three paths in one cycle
    v = idle(3'd3, 16'h1111); v.wr_row = 8'h08; v.clause = 16'h1111;
    v.wr_var = 8'h01; v.vs_value = 16'h0001; v.vs_level = 128'h7;
    v.wr_lvl = 8'h01; v.ls_dcd = 80'h5; vecs.push_back(v);
    // 16-17: reset mid-load, then release with no writes
    v = idle(3'd3, 16'h0000); v.rst = 1'b0; v.wr_row = 8'h08; v.clause = 16'h2222;
    v.wr_var = 8'hFF; v.vs_value = 16'h5555; vecs.push_back(v);
    vecs.push_back(idle(3'd3, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      if (i == 8) begin
        check("var0_state", 256'(vars_states_o[18:0]), 256'(19'h50005));
        check("vars_rest_zero", 256'(vars_states_o[151:19]), 256'(0));
      end
      if (i == 9) begin
        check("var0_held", 256'(vars_states_o[18:0]), 256'(19'h50005));
        check("var1_state", 256'(vars_states_o[37:19]), 256'(19'h20009));
      end
      if (i == 10) check("lvl0_state", 256'(lvl_states_o[10:0]), 256'(11'h007));
      if (i == 11) begin
        check("lvl7_state", 256'(lvl_states_o[87:77]), 256'(11'h7FE));
        check("lvl0_held", 256'(lvl_states_o[10:0]), 256'(11'h007));
      end
      if (i == 13) check("row0_multi", 256'(carray_o[15:0]), 256'(16'hAAAA));
      if (i == 14 || i == 16 || i == 17) begin
        check($sformatf("v%0d all_zero", i),
              256'({carray_o, vars_states_o[103:0]}), 256'(0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
